// File: rtl/legv8_pkg.sv
// Shared fetch-path types and constants.
// Entry layout is {pc, instr}, pc in the upper bits.
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instructions are word aligned; drop the byte offset.
    function automatic logic [ADDR_W-1:0] align_pc(
        input logic [ADDR_W-1:0] pc
    );
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between fetch and decode.
// Flush beats push/pop; push is accepted when full if a pop happens too.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    // Pointer and occupancy next-state; flush empties the queue.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge clk_i) begin
        if (!flush_i && do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC register, instruction-memory request,
// and a fetch queue feeding decode over valid/ready.
module instruction_fetch_unit
    import legv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              enq;
    logic              deq;
    logic              fq_empty;
    logic [CNT_W-1:0]  fq_count;
    fetch_entry_t      tail_entry;
    fetch_entry_t      head_entry;

    assign imem_addr = pc_q;

    // A redirect holds the head in place; the flush discards it anyway.
    assign deq = id_valid & id_ready & ~redirect_valid;
    assign enq = ~redirect_valid & ((fq_count < DEPTH_C) | deq);

    assign tail_entry.pc    = pc_q;
    assign tail_entry.instr = imem_data;

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fq (
        .clk_i       (CLK),
        .rst_n_i     (resetl),
        .flush_i     (redirect_valid),
        .push_i      (enq),
        .push_data_i (tail_entry),
        .pop_i       (deq),
        .head_o      (head_entry),
        .empty_o     (fq_empty),
        .count_o     (fq_count)
    );

    // Queue head reads back as zero when empty, so decode never sees X.
    assign id_valid = ~fq_empty;
    assign id_instr = head_entry.instr;
    assign id_pc    = head_entry.pc;

    // Next PC: redirect target, sequential advance, or hold on stall.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (enq) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC register.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of the fetch unit
// against a queue-based reference model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetl;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    logic        resetl2;
    logic [63:0] imem_addr2;
    logic [31:0] imem_data2;
    logic        redirect_valid2;
    logic [63:0] redirect_pc2;
    logic        id_valid2;
    logic        id_ready2;
    logic [31:0] id_instr2;
    logic [63:0] id_pc2;

    assign imem_data  = {16'hC0DE, imem_addr[15:0]};
    assign imem_data2 = {16'hC0DE, imem_addr2[15:0]};

    instruction_fetch_unit #(
        .RESET_PC (64'h0),
        .FQ_DEPTH (2)
    ) dut (
        .CLK            (clk),
        .resetl         (resetl),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    instruction_fetch_unit #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC),
        .FQ_DEPTH (2)
    ) dut_wrap (
        .CLK            (clk),
        .resetl         (resetl2),
        .imem_addr      (imem_addr2),
        .imem_data      (imem_data2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .id_valid       (id_valid2),
        .id_ready       (id_ready2),
        .id_instr       (id_instr2),
        .id_pc          (id_pc2)
    );

    int ncmp = 0;
    int nerr = 0;

    // Reference model: list of fetched {pc, instr} words plus next address.
    logic [95:0] mq[$];
    logic [63:0] mpc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit take;
        bit room;
        if (!resetl) begin
            mq.delete();
            mpc = 64'h0;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_pc[63:2], 2'b00};
        end else begin
            take = (mq.size() > 0) && id_ready;
            room = (mq.size() < 2) || take;
            if (take) void'(mq.pop_front());
            if (room) begin
                mq.push_back({mpc, mem_word(mpc)});
                mpc = mpc + 64'd4;
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic [95:0] h;
        h = (mq.size() > 0) ? mq[0] : 96'h0;
        chk({tag, ".valid"}, 64'(id_valid), 64'(mq.size() > 0));
        chk({tag, ".pc"}, id_pc, h[95:32]);
        chk({tag, ".instr"}, 64'(id_instr), 64'(h[31:0]));
        chk({tag, ".addr"}, imem_addr, mpc);
    endtask

    // One clock: advance model with the inputs at the edge, then compare.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        model_check(tag);
    endtask

    initial begin
        resetl          = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        id_ready        = 1'b0;
        resetl2         = 1'b0;
        redirect_valid2 = 1'b0;
        redirect_pc2    = 64'h0;
        id_ready2       = 1'b1;

        cyc("rst");
        chk("rst.valid", 64'(id_valid), 64'h0);
        chk("rst.pc", id_pc, 64'h0);
        chk("rst.instr", 64'(id_instr), 64'h0);
        chk("rst.addr", imem_addr, 64'h0);

        // 1: streaming with decode always ready
        resetl   = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc("t1");
            chk("t1.valid", 64'(id_valid), 64'h1);
            chk("t1.pc", id_pc, 64'(4 * i));
            chk("t1.instr", 64'(id_instr), 64'(32'hC0DE0000 + 4 * i));
        end

        // 2: stall until full, then drain back-to-back
        resetl = 1'b0;
        cyc("t2r");
        resetl   = 1'b1;
        id_ready = 1'b0;
        repeat (5) cyc("t2s");
        chk("t2.full_pc", id_pc, 64'h0);
        chk("t2.hold_addr", imem_addr, 64'h8);
        id_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cyc("t2d");
            chk("t2.valid", 64'(id_valid), 64'h1);
            chk("t2.pc", id_pc, 64'(4 * i));
        end

        // 3: redirect while full
        id_ready = 1'b0;
        repeat (3) cyc("t3f");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5C;
        id_ready       = 1'b1;
        cyc("t3a");
        chk("t3.flush_valid", 64'(id_valid), 64'h0);
        chk("t3.addr", imem_addr, 64'h5C);
        redirect_valid = 1'b0;
        cyc("t3b");
        chk("t3.pc", id_pc, 64'h5C);
        chk("t3.instr", 64'(id_instr), 64'hC0DE005C);

        // 4: misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 64'h47;
        cyc("t4a");
        redirect_valid = 1'b0;
        cyc("t4b");
        chk("t4.pc", id_pc, 64'h44);
        chk("t4.instr", 64'(id_instr), 64'hC0DE0044);

        // 6: reset beats a simultaneous redirect
        cyc("t6m");
        resetl         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1230;
        cyc("t6");
        chk("t6.valid", 64'(id_valid), 64'h0);
        chk("t6.pc", id_pc, 64'h0);
        chk("t6.instr", 64'(id_instr), 64'h0);
        chk("t6.addr", imem_addr, 64'h0);
        redirect_valid = 1'b0;
        resetl         = 1'b1;

        // Random traffic: back-pressure, redirects, occasional reset
        for (int i = 0; i < 400; i++) begin
            id_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = {$urandom(), $urandom()};
            resetl         = ($urandom_range(0, 63) != 0);
            cyc("rnd");
        end
        resetl         = 1'b1;
        redirect_valid = 1'b0;

        // 5: PC wraps past the top of the address space
        @(posedge clk);
        #1;
        resetl2 = 1'b1;
        chk("t5.addr0", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5.valid0", 64'(id_valid2), 64'h0);
        @(posedge clk);
        #1;
        chk("t5.pc0", id_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5.instr0", 64'(id_instr2), 64'hC0DEFFFC);
        chk("t5.addr1", imem_addr2, 64'h0);
        @(posedge clk);
        #1;
        chk("t5.pc1", id_pc2, 64'h0);
        chk("t5.instr1", 64'(id_instr2), 64'hC0DE0000);
        chk("t5.valid1", 64'(id_valid2), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
